// File: rtl/fnd_demux_if.sv
// fnd_demux_if
//   Bundles the FND scan bus seen by the demultiplexer together with the
//   rebuilt digit outputs.
//   Parameter:
//     ERR_W      - width of the saturating error counter
//   Signals:
//     mux_sel    - active-low digit select from the scan driver
//     mux_out    - digit value on the shared bus
//     dig0..dig3 - reconstructed digit values
//     frame_done - one-cycle pulse per completed frame
//     sel_err    - one-cycle pulse on an illegal / out-of-order select
//     err_cnt    - saturating count of sel_err pulses
//   Modports:
//     master - scan-bus driver side (drives mux_sel/mux_out, observes results)
//     slave  - demultiplexer side
interface fnd_demux_if #(
  parameter int unsigned ERR_W = 8
) ();
  logic [3:0]       mux_sel;
  logic [3:0]       mux_out;
  logic [3:0]       dig0;
  logic [3:0]       dig1;
  logic [3:0]       dig2;
  logic [3:0]       dig3;
  logic             frame_done;
  logic             sel_err;
  logic [ERR_W-1:0] err_cnt;

  modport master (
    output mux_sel, mux_out,
    input  dig0, dig1, dig2, dig3, frame_done, sel_err, err_cnt
  );

  modport slave (
    input  mux_sel, mux_out,
    output dig0, dig1, dig2, dig3, frame_done, sel_err, err_cnt
  );
endinterface

// File: rtl/fnd_demux.sv
// fnd_demux
//   Receiving end of the four-digit multiplexed FND scan bus. Registers the
//   shared digit value and active-low select, filters unstable patterns,
//   rebuilds the four digit values, flags illegal (and optionally
//   out-of-order) selects and signals completed scan frames.
//   Parameters:
//     STABLE_CYCLES - identical samples needed before a pattern is accepted (1..15)
//     ERR_W         - width of the saturating error counter
//   Ports:
//     clk - system clock, rising edge
//     rst - synchronous, active-high reset
//     bus - fnd_demux_if.slave: mux_sel/mux_out in; dig0..3, frame_done,
//           sel_err, err_cnt out
//   Build option:
//     FND_DEMUX_SEQCHK_EN - when defined, a sequence FSM enforces digit order
//                           0,1,2,3 per frame; when undefined, frame_done
//                           pulses on every accepted digit 3 and only
//                           illegal patterns raise sel_err.
module fnd_demux #(
  parameter int unsigned STABLE_CYCLES = 1,
  parameter int unsigned ERR_W         = 8
) (
  input logic        clk,
  input logic        rst,
  fnd_demux_if.slave bus
);

  localparam logic [3:0] STAB = 4'(STABLE_CYCLES);

  logic [3:0]       r_s_sel;
  logic [3:0]       r_s_val;
  logic [3:0]       r_p_sel;
  logic [3:0]       r_p_val;
  logic [3:0]       r_stab;
  logic [3:0]       r_dig0;
  logic [3:0]       r_dig1;
  logic [3:0]       r_dig2;
  logic [3:0]       r_dig3;
  logic             r_frame_done;
  logic             r_sel_err;
  logic [ERR_W-1:0] r_err_cnt;

  logic       w_same;
  logic [3:0] w_stab_nxt;
  logic       w_accept;
  logic       w_legal;
  logic       w_blank;
  logic [1:0] w_idx;
  logic       w_illegal;
  logic       w_legal_acc;
  logic       w_seq_err;
  logic       w_frame;
  logic       w_err;

  // Stability filter. Accept fires when the counter reaches STAB either by
  // counting up or by reloading 1 on a change; the second term keeps a held
  // pattern from re-firing once the counter sits saturated at STAB, while
  // still letting STAB=1 accept a new pattern every clock.
  always_comb begin
    w_same = ({r_s_sel, r_s_val} == {r_p_sel, r_p_val});
    if (!w_same)
      w_stab_nxt = 4'd1;
    else if (r_stab >= STAB)
      w_stab_nxt = STAB;
    else
      w_stab_nxt = r_stab + 4'd1;
    w_accept = (w_stab_nxt == STAB) && (!w_same || (r_stab != STAB));
  end

  always_comb begin
    w_legal = 1'b1;
    w_blank = 1'b0;
    w_idx   = 2'd0;
    case (r_s_sel)
      4'b1110: w_idx = 2'd0;
      4'b1101: w_idx = 2'd1;
      4'b1011: w_idx = 2'd2;
      4'b0111: w_idx = 2'd3;
      4'b1111: begin
        w_legal = 1'b0;
        w_blank = 1'b1;
      end
      default: w_legal = 1'b0;
    endcase
    w_illegal   = w_accept && !w_legal && !w_blank;
    w_legal_acc = w_accept && w_legal;
  end

`ifdef FND_DEMUX_SEQCHK_EN
  // Encodings chosen so EXPn numerically equals the digit index it expects.
  typedef enum logic [1:0] {
    SYNC = 2'd0,
    EXP1 = 2'd1,
    EXP2 = 2'd2,
    EXP3 = 2'd3
  } state_t;

  state_t     r_state;
  logic [1:0] w_exp_idx;

  always_comb begin
    w_exp_idx = r_state;
    w_seq_err = w_legal_acc && (r_state != SYNC) && (w_idx != w_exp_idx);
    w_frame   = w_legal_acc && (r_state == EXP3) && (w_idx == 2'd3);
  end
`else
  always_comb begin
    w_seq_err = 1'b0;
    w_frame   = w_legal_acc && (w_idx == 2'd3);
  end
`endif

  assign w_err = w_illegal || w_seq_err;

  // Input stage, stability counter and digit registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s_sel <= 4'b1111;
      r_s_val <= '0;
      r_p_sel <= 4'b1111;
      r_p_val <= '0;
      r_stab  <= '0;
      r_dig0  <= '0;
      r_dig1  <= '0;
      r_dig2  <= '0;
      r_dig3  <= '0;
    end else begin
      r_s_sel <= bus.mux_sel;
      r_s_val <= bus.mux_out;
      r_p_sel <= r_s_sel;
      r_p_val <= r_s_val;
      r_stab  <= w_stab_nxt;
      if (w_legal_acc) begin
        case (w_idx)
          2'd0:    r_dig0 <= r_s_val;
          2'd1:    r_dig1 <= r_s_val;
          2'd2:    r_dig2 <= r_s_val;
          default: r_dig3 <= r_s_val;
        endcase
      end
    end
  end

  // Sequence tracking, frame/error pulses and saturating error counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame_done <= 1'b0;
      r_sel_err    <= 1'b0;
      r_err_cnt    <= '0;
`ifdef FND_DEMUX_SEQCHK_EN
      r_state      <= SYNC;
`endif
    end else begin
      r_frame_done <= w_frame;
      r_sel_err    <= w_err;
      if (w_err && (r_err_cnt != '1))
        r_err_cnt <= r_err_cnt + ERR_W'(1);
`ifdef FND_DEMUX_SEQCHK_EN
      if (w_illegal) begin
        r_state <= SYNC;
      end else if (w_legal_acc) begin
        // Digit 0 always (re)starts a frame, from any state.
        if (w_idx == 2'd0)
          r_state <= EXP1;
        else if ((r_state != SYNC) && (w_idx == w_exp_idx))
          r_state <= (w_idx == 2'd3) ? SYNC : state_t'(w_idx + 2'd1);
        else
          r_state <= SYNC;
      end
`endif
    end
  end

  assign bus.dig0       = r_dig0;
  assign bus.dig1       = r_dig1;
  assign bus.dig2       = r_dig2;
  assign bus.dig3       = r_dig3;
  assign bus.frame_done = r_frame_done;
  assign bus.sel_err    = r_sel_err;
  assign bus.err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_fnd_demux.sv
// tb_fnd_demux
//   Self-checking bench for fnd_demux. Three instances share one scan bus:
//     a: STABLE_CYCLES=1, ERR_W=8
//     b: STABLE_CYCLES=3, ERR_W=8
//     c: STABLE_CYCLES=1, ERR_W=2
//   A reference model keeps the sampled bus history and derives acceptance
//   from the length of the trailing run of identical samples.
module tb_fnd_demux;

`ifdef FND_DEMUX_SEQCHK_EN
  localparam bit SEQ = 1'b1;
`else
  localparam bit SEQ = 1'b0;
`endif

  localparam int unsigned M_STAB [3] = '{1, 3, 1};
  localparam int unsigned M_EMAX [3] = '{255, 255, 3};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] sel = 4'hF;
  logic [3:0] val = 4'h0;

  always #5 clk = ~clk;

  fnd_demux_if #(.ERR_W(8)) bus_a ();
  fnd_demux_if #(.ERR_W(8)) bus_b ();
  fnd_demux_if #(.ERR_W(2)) bus_c ();

  assign bus_a.mux_sel = sel;
  assign bus_a.mux_out = val;
  assign bus_b.mux_sel = sel;
  assign bus_b.mux_out = val;
  assign bus_c.mux_sel = sel;
  assign bus_c.mux_out = val;

  fnd_demux #(.STABLE_CYCLES(1), .ERR_W(8)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  fnd_demux #(.STABLE_CYCLES(3), .ERR_W(8)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));
  fnd_demux #(.STABLE_CYCLES(1), .ERR_W(2)) dut_c (.clk(clk), .rst(rst), .bus(bus_c));

  logic [3:0] o_dig [3][4];
  logic       o_fd  [3];
  logic       o_se  [3];
  logic [7:0] o_ec  [3];

  always_comb begin
    o_dig[0][0] = bus_a.dig0; o_dig[0][1] = bus_a.dig1;
    o_dig[0][2] = bus_a.dig2; o_dig[0][3] = bus_a.dig3;
    o_dig[1][0] = bus_b.dig0; o_dig[1][1] = bus_b.dig1;
    o_dig[1][2] = bus_b.dig2; o_dig[1][3] = bus_b.dig3;
    o_dig[2][0] = bus_c.dig0; o_dig[2][1] = bus_c.dig1;
    o_dig[2][2] = bus_c.dig2; o_dig[2][3] = bus_c.dig3;
    o_fd[0] = bus_a.frame_done; o_fd[1] = bus_b.frame_done; o_fd[2] = bus_c.frame_done;
    o_se[0] = bus_a.sel_err;    o_se[1] = bus_b.sel_err;    o_se[2] = bus_c.sel_err;
    o_ec[0] = bus_a.err_cnt;    o_ec[1] = bus_b.err_cnt;    o_ec[2] = {6'b0, bus_c.err_cnt};
  end

  int npass  = 0;
  int ntotal = 0;

  // Reference model state
  logic [7:0]  hist [$];
  int unsigned m_dig [3][4];
  int          m_pos [3];   // digits seen in order within current frame
  bit          m_fd  [3];
  bit          m_se  [3];
  int unsigned m_ec  [3];

  task automatic model_accept(input int i, input logic [7:0] ev);
    int idx;
    case (ev[7:4])
      4'b1110: idx = 0;
      4'b1101: idx = 1;
      4'b1011: idx = 2;
      4'b0111: idx = 3;
      4'b1111: idx = -1;
      default: idx = -2;
    endcase
    if (idx == -1) return;
    if (idx == -2) begin
      m_se[i]  = 1'b1;
      m_pos[i] = 0;
    end else begin
      m_dig[i][idx] = ev[3:0];
      if (SEQ) begin
        if (m_pos[i] == 0) begin
          if (idx == 0) m_pos[i] = 1;
        end else if (idx == m_pos[i]) begin
          if (idx == 3) begin
            m_fd[i]  = 1'b1;
            m_pos[i] = 0;
          end else begin
            m_pos[i] = m_pos[i] + 1;
          end
        end else begin
          m_se[i]  = 1'b1;
          m_pos[i] = (idx == 0) ? 1 : 0;
        end
      end else if (idx == 3) begin
        m_fd[i] = 1'b1;
      end
    end
    if (m_se[i] && (m_ec[i] < M_EMAX[i])) m_ec[i] = m_ec[i] + 1;
  endtask

  // Drive one bus pattern across one rising edge, advance the model, then
  // leave the bench 1 time unit after the edge for sampling.
  task automatic step(input logic [3:0] s, input logic [3:0] v, input logic r);
    int unsigned run;
    logic [7:0]  ev;
    sel = s;
    val = v;
    rst = r;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      m_fd[i] = 1'b0;
      m_se[i] = 1'b0;
    end
    if (r) begin
      hist.delete();
      hist.push_back(8'hF0);
      for (int i = 0; i < 3; i++) begin
        for (int d = 0; d < 4; d++) m_dig[i][d] = 0;
        m_pos[i] = 0;
        m_ec[i]  = 0;
      end
    end else begin
      ev  = hist[$];
      run = 0;
      for (int j = hist.size() - 1; j >= 0; j--) begin
        if (hist[j] == ev) run++;
        else break;
      end
      for (int i = 0; i < 3; i++)
        if (run == M_STAB[i]) model_accept(i, ev);
      hist.push_back({s, v});
      if (hist.size() > 20) void'(hist.pop_front());
    end
    #1;
  endtask

  task automatic test_reset();
    step(4'hF, 4'h0, 1'b1);
    step(4'hF, 4'h0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      for (int d = 0; d < 4; d++) begin
        ntotal++;
        if (o_dig[i][d] !== 4'h0) $display("FAIL reset_dig inst%0d dig%0d got %0h exp 0", i, d, o_dig[i][d]);
        else npass++;
      end
      ntotal++;
      if (o_fd[i] !== 1'b0) $display("FAIL reset_frame_done inst%0d got %b exp 0", i, o_fd[i]);
      else npass++;
      ntotal++;
      if (o_se[i] !== 1'b0) $display("FAIL reset_sel_err inst%0d got %b exp 0", i, o_se[i]);
      else npass++;
      ntotal++;
      if (o_ec[i] !== 8'h0) $display("FAIL reset_err_cnt inst%0d got %0d exp 0", i, o_ec[i]);
      else npass++;
    end
  endtask

  task automatic test_ordered_scan();
    logic [3:0] ps [7] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'hF, 4'hF, 4'hF};
    logic [3:0] pv [7] = '{4'd3, 4'd7, 4'd2, 4'd9, 4'd0, 4'd0, 4'd0};
    int fd_cnt = 0, se_cnt = 0, fd_at = -1;
    logic [3:0] dig3_at_fd = 4'h0;
    step(4'hF, 4'h0, 1'b1);
    for (int k = 0; k < 7; k++) begin
      step(ps[k], pv[k], 1'b0);
      if (o_fd[0] === 1'b1) begin
        fd_cnt++;
        fd_at = k;
        dig3_at_fd = o_dig[0][3];
      end
      if (o_se[0] === 1'b1) se_cnt++;
      ntotal++;
      if (o_fd[0] !== m_fd[0]) $display("FAIL ordered_fd step%0d got %b exp %b", k, o_fd[0], m_fd[0]);
      else npass++;
    end
    for (int d = 0; d < 4; d++) begin
      ntotal++;
      if (o_dig[0][d] !== pv[d]) $display("FAIL ordered_dig%0d got %0d exp %0d", d, o_dig[0][d], pv[d]);
      else npass++;
    end
    ntotal++;
    if (fd_cnt !== 1) $display("FAIL ordered_fd_count got %0d exp 1", fd_cnt);
    else npass++;
    ntotal++;
    if (fd_at !== 4) $display("FAIL ordered_fd_latency got step %0d exp step 4", fd_at);
    else npass++;
    ntotal++;
    if (dig3_at_fd !== 4'd9) $display("FAIL ordered_dig3_with_fd got %0d exp 9", dig3_at_fd);
    else npass++;
    ntotal++;
    if (se_cnt !== 0) $display("FAIL ordered_sel_err_count got %0d exp 0", se_cnt);
    else npass++;
  endtask

  task automatic test_illegal_select();
    logic [3:0] ps [6] = '{4'b1101, 4'hF, 4'b1100, 4'hF, 4'hF, 4'hF};
    logic [3:0] pv [6] = '{4'd6, 4'd0, 4'd5, 4'd0, 4'd0, 4'd0};
    int se_cnt = 0;
    step(4'hF, 4'h0, 1'b1);
    for (int k = 0; k < 6; k++) begin
      step(ps[k], pv[k], 1'b0);
      if (o_se[0] === 1'b1) se_cnt++;
      ntotal++;
      if (o_se[0] !== m_se[0]) $display("FAIL illegal_se step%0d got %b exp %b", k, o_se[0], m_se[0]);
      else npass++;
    end
    ntotal++;
    if (se_cnt !== 1) $display("FAIL illegal_se_count got %0d exp 1", se_cnt);
    else npass++;
    ntotal++;
    if (o_ec[0] !== 8'd1) $display("FAIL illegal_err_cnt got %0d exp 1", o_ec[0]);
    else npass++;
    ntotal++;
    if ({o_dig[0][0], o_dig[0][1], o_dig[0][2], o_dig[0][3]} !== 16'h0600)
      $display("FAIL illegal_digits got %h exp 0600",
               {o_dig[0][0], o_dig[0][1], o_dig[0][2], o_dig[0][3]});
    else npass++;
  endtask

  task automatic test_out_of_order();
    logic [3:0] ps [16] = '{4'b1110, 4'b1011, 4'b1101, 4'b1011, 4'b0111, 4'hF, 4'hF, 4'hF,
                            4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'hF, 4'hF, 4'hF, 4'hF};
    int se1 = 0, fd1 = 0, se2 = 0, fd2 = 0;
    step(4'hF, 4'h0, 1'b1);
    for (int k = 0; k < 16; k++) begin
      step(ps[k], 4'(k), 1'b0);
      if (k < 8) begin
        if (o_se[0] === 1'b1) se1++;
        if (o_fd[0] === 1'b1) fd1++;
      end else begin
        if (o_se[0] === 1'b1) se2++;
        if (o_fd[0] === 1'b1) fd2++;
      end
    end
    ntotal++;
    if (se1 !== (SEQ ? 1 : 0)) $display("FAIL ooo_se_phase1 got %0d exp %0d", se1, SEQ ? 1 : 0);
    else npass++;
    ntotal++;
    if (fd1 !== (SEQ ? 0 : 1)) $display("FAIL ooo_fd_phase1 got %0d exp %0d", fd1, SEQ ? 0 : 1);
    else npass++;
    ntotal++;
    if (se2 !== 0) $display("FAIL ooo_se_phase2 got %0d exp 0", se2);
    else npass++;
    ntotal++;
    if (fd2 !== 1) $display("FAIL ooo_fd_phase2 got %0d exp 1", fd2);
    else npass++;
  endtask

  task automatic test_stability();
    step(4'hF, 4'h0, 1'b1);
    step(4'hF, 4'h0, 1'b0);
    step(4'b1101, 4'd4, 1'b0);
    step(4'b1101, 4'd4, 1'b0);
    for (int k = 0; k < 4; k++) step(4'hF, 4'h0, 1'b0);
    ntotal++;
    if (o_dig[1][1] !== 4'd0) $display("FAIL stab_short_hold dig1 got %0d exp 0", o_dig[1][1]);
    else npass++;
    ntotal++;
    if (o_dig[0][1] !== 4'd4) $display("FAIL stab1_short_hold dig1 got %0d exp 4", o_dig[0][1]);
    else npass++;
    for (int k = 0; k < 5; k++) begin
      step(4'b1101, 4'd4, 1'b0);
      if (k == 2) begin
        ntotal++;
        if (o_dig[1][1] !== 4'd0) $display("FAIL stab_early dig1 got %0d exp 0", o_dig[1][1]);
        else npass++;
      end
      if (k == 3) begin
        ntotal++;
        if (o_dig[1][1] !== 4'd4) $display("FAIL stab_latency dig1 got %0d exp 4", o_dig[1][1]);
        else npass++;
      end
    end
    for (int k = 0; k < 4; k++) step(4'hF, 4'h0, 1'b0);
    ntotal++;
    if (o_dig[1][1] !== 4'd4) $display("FAIL stab_long_hold dig1 got %0d exp 4", o_dig[1][1]);
    else npass++;
    ntotal++;
    if (o_se[1] !== 1'b0 || o_ec[1] !== 8'd0)
      $display("FAIL stab_no_err sel_err %b err_cnt %0d exp 0 0", o_se[1], o_ec[1]);
    else npass++;
  endtask

  task automatic test_reset_mid_frame();
    int fd_cnt = 0;
    step(4'hF, 4'h0, 1'b1);
    step(4'b1110, 4'd1, 1'b0);
    step(4'b1101, 4'd2, 1'b0);
    step(4'hF, 4'h0, 1'b0);
    step(4'hF, 4'h0, 1'b1);
    ntotal++;
    if ({o_dig[0][0], o_dig[0][1], o_dig[0][2], o_dig[0][3], o_fd[0], o_se[0], o_ec[0]} !== 26'h0)
      $display("FAIL midrst_clear got dig %h fd %b se %b ec %0d exp all 0",
               {o_dig[0][0], o_dig[0][1], o_dig[0][2], o_dig[0][3]}, o_fd[0], o_se[0], o_ec[0]);
    else npass++;
    step(4'b1011, 4'd3, 1'b0);
    if (o_fd[0] === 1'b1) fd_cnt++;
    step(4'b0111, 4'd4, 1'b0);
    if (o_fd[0] === 1'b1) fd_cnt++;
    for (int k = 0; k < 3; k++) begin
      step(4'hF, 4'h0, 1'b0);
      if (o_fd[0] === 1'b1) fd_cnt++;
    end
    ntotal++;
    if (fd_cnt !== (SEQ ? 0 : 1)) $display("FAIL midrst_fd_count got %0d exp %0d", fd_cnt, SEQ ? 0 : 1);
    else npass++;
    ntotal++;
    if ({o_dig[0][2], o_dig[0][3]} !== 8'h34)
      $display("FAIL midrst_digits got %h exp 34", {o_dig[0][2], o_dig[0][3]});
    else npass++;
  endtask

  task automatic test_saturation();
    logic [3:0] ps [5] = '{4'b1100, 4'b0000, 4'b1010, 4'b0011, 4'b1000};
    int se_cnt = 0;
    step(4'hF, 4'h0, 1'b1);
    for (int k = 0; k < 8; k++) begin
      if (k < 5) step(ps[k], 4'(k + 1), 1'b0);
      else step(4'hF, 4'h0, 1'b0);
      if (o_se[2] === 1'b1) se_cnt++;
    end
    ntotal++;
    if (se_cnt !== 5) $display("FAIL sat_se_count got %0d exp 5", se_cnt);
    else npass++;
    ntotal++;
    if (o_ec[2] !== 8'd3) $display("FAIL sat_err_cnt got %0d exp 3", o_ec[2]);
    else npass++;
    ntotal++;
    if (o_ec[0] !== 8'd5) $display("FAIL sat_wide_err_cnt got %0d exp 5", o_ec[0]);
    else npass++;
  endtask

  task automatic test_random();
    logic [3:0] s;
    logic [3:0] v;
    int unsigned pick;
    int unsigned hold;
    step(4'hF, 4'h0, 1'b1);
    for (int n = 0; n < 300; n++) begin
      pick = $urandom_range(0, 9);
      if (pick < 6) s = ~(4'b0001 << pick[1:0]);
      else if (pick < 8) s = 4'hF;
      else s = 4'($urandom);
      v    = 4'($urandom);
      hold = $urandom_range(1, 4);
      for (int h = 0; h < int'(hold); h++) begin
        step(s, v, ($urandom_range(0, 99) == 0));
        for (int i = 0; i < 3; i++) begin
          for (int d = 0; d < 4; d++) begin
            ntotal++;
            if (o_dig[i][d] !== 4'(m_dig[i][d]))
              $display("FAIL rand_dig inst%0d dig%0d got %0d exp %0d", i, d, o_dig[i][d], m_dig[i][d]);
            else npass++;
          end
          ntotal++;
          if (o_fd[i] !== m_fd[i]) $display("FAIL rand_fd inst%0d got %b exp %b", i, o_fd[i], m_fd[i]);
          else npass++;
          ntotal++;
          if (o_se[i] !== m_se[i]) $display("FAIL rand_se inst%0d got %b exp %b", i, o_se[i], m_se[i]);
          else npass++;
          ntotal++;
          if (o_ec[i] !== 8'(m_ec[i])) $display("FAIL rand_ec inst%0d got %0d exp %0d", i, o_ec[i], m_ec[i]);
          else npass++;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_ordered_scan();
    test_illegal_select();
    test_out_of_order();
    test_stability();
    test_reset_mid_frame();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
